// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter: CPU-written byte FIFO drained as 8N1 serial frames.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing, STATUS bit4 = 1).
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CW   = PTRW + 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r;
    state_t          state_r;
    logic [CNTW-1:0] cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            par_r;
    logic            ovf_r;
    logic [31:0]     rdata_r;
    logic            tx_r;

    logic        full_s, empty_s, bit_end_s, pop_s, wr_s, push_s, drop_s, stat_rd_s, tx_s;
    logic [31:0] status_s;

    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == {CW{1'b0}});
    assign bit_end_s = (cnt_r == CNT_MAX);
    // A pop happens whenever the transmitter is ready for a new byte: idle, or at the last STOP cycle.
    assign pop_s     = !empty_s && ((state_r == S_IDLE) || ((state_r == S_STOP) && bit_end_s));
    assign wr_s      = sel && we && (addr == 2'd0);
    assign push_s    = wr_s && (!full_s || pop_s);
    assign drop_s    = wr_s && full_s && !pop_s;
    assign stat_rd_s = sel && re && (addr == 2'd1);

    // STATUS register image
    always_comb begin
        status_s       = 32'd0;
        status_s[0]    = full_s;
        status_s[1]    = empty_s;
        status_s[2]    = (state_r != S_IDLE);
        status_s[3]    = ovf_r;
`ifdef MMIO_UART_TX_PARITY_EN
        status_s[4]    = 1'b1;
`else
        status_s[4]    = 1'b0;
`endif
        status_s[11:8] = 4'(count_r);
    end

    // Serial line level for the current state; registered below
    always_comb begin
        case (state_r)
            S_IDLE:   tx_s = 1'b1;
            S_START:  tx_s = 1'b0;
            S_DATA:   tx_s = shift_r[0];
            S_PARITY: tx_s = par_r;
            S_STOP:   tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
    end

    // Byte FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTRW{1'b0}};
            rd_ptr_r <= {PTRW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata[7:0];
                wr_ptr_r        <= wr_ptr_r + PTRW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTRW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Transmitter FSM with registered tx
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNTW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            par_r     <= 1'b0;
            tx_r      <= 1'b1;
        end else begin
            tx_r <= tx_s;
            case (state_r)
                S_IDLE: begin
                    cnt_r <= {CNTW{1'b0}};
                    if (pop_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        par_r   <= even_parity(mem_r[rd_ptr_r]);
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        cnt_r     <= {CNTW{1'b0}};
                        bit_idx_r <= 3'd0;
                        state_r   <= S_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNTW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        cnt_r   <= {CNTW{1'b0}};
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                            state_r <= S_PARITY;
`else
                            state_r <= S_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNTW'(1);
                    end
                end
`ifdef MMIO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end_s) begin
                        cnt_r   <= {CNTW{1'b0}};
                        state_r <= S_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNTW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= {CNTW{1'b0}};
                        // Chain straight into the next frame when a byte is waiting
                        if (pop_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                            par_r   <= even_parity(mem_r[rd_ptr_r]);
                            state_r <= S_START;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNTW'(1);
                    end
                end
                default: begin
                    cnt_r   <= {CNTW{1'b0}};
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Bus read data and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= 32'd0;
            ovf_r   <= 1'b0;
        end else begin
            if (sel && re) begin
                case (addr)
                    2'd1:    rdata_r <= status_s;
                    default: rdata_r <= 32'd0;
                endcase
            end else begin
                rdata_r <= rdata_r;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (stat_rd_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign rdata = rdata_r;
    assign tx    = tx_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue/frame-index reference model compared every cycle, plus literal spot checks.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          NBITS   = 11;
    localparam logic        PAR     = 1'b1;
    localparam logic [31:0] IDLE_ST = 32'h12;
    localparam logic [10:0] EXP55   = 11'h4AA;
`else
    localparam int          NBITS   = 10;
    localparam logic        PAR     = 1'b0;
    localparam logic [31:0] IDLE_ST = 32'h2;
    localparam logic [10:0] EXP55   = 11'h2AA;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0, re = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        tx;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .re(re), .we(we),
        .wdata(wdata), .rdata(rdata), .tx(tx)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: byte queue plus an index into the current frame's bit list
    logic [7:0]  m_q[$];
    bit          m_busy = 1'b0;
    int          m_t = 0;
    logic [10:0] m_frame = 11'h7FF;
    logic        m_ovf = 1'b0;
    logic        m_tx = 1'b1;
    logic [31:0] m_rdata = 32'd0;

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        logic [10:0] f;
        f = 11'h7FF;
        f[0] = 1'b0;
        f[8:1] = b;
        if (PAR) f[9] = ^b;
        return f;
    endfunction

    task automatic model_step();
        int sz;
        bit pop, wr, accept, drop;
        logic txn;
        if (reset) begin
            m_q.delete();
            m_busy = 1'b0; m_t = 0; m_ovf = 1'b0; m_tx = 1'b1; m_rdata = 32'd0;
            return;
        end
        sz = m_q.size();
        pop = (sz > 0) && (!m_busy || (m_t == FRAME - 1));
        wr = sel && we && (addr == 2'd0);
        accept = wr && ((sz < DEPTH) || pop);
        drop = wr && !accept;
        if (sel && re) begin
            if (addr == 2'd1)
                m_rdata = {20'd0, 4'(sz), 3'd0, PAR, m_ovf, m_busy, sz == 0, sz == DEPTH};
            else
                m_rdata = 32'd0;
        end
        txn = m_busy ? m_frame[m_t / CPB] : 1'b1;
        if (drop) m_ovf = 1'b1;
        else if (sel && re && addr == 2'd1) m_ovf = 1'b0;
        if (pop) begin
            m_frame = make_frame(m_q.pop_front());
            m_busy = 1'b1;
            m_t = 0;
        end else if (m_busy) begin
            if (m_t == FRAME - 1) m_busy = 1'b0;
            else m_t++;
        end
        if (accept) m_q.push_back(wdata[7:0]);
        m_tx = txn;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("tx", {31'd0, tx}, {31'd0, m_tx});
            check("rdata", rdata, m_rdata);
        end
    end

    // Bus helpers: called at a negedge, return at the next negedge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic s);
        sel = s; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        sel = 1'b1; re = 1'b1; addr = a;
        @(negedge clk);
        v = rdata;
        sel = 1'b0; re = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            sel = 1'b1; we = 1'b1; addr = 2'd0; wdata = {24'hFFFFFF, first + 8'(i)};
            @(negedge clk);
        end
        sel = 1'b0; we = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        // Reset then idle
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rdata", rdata, 32'd0);
        bus_read(2'd1, v);
        check("idle_status", v, IDLE_ST);

        // Accesses that must have no effect: deselected write, STATUS write, reserved read
        bus_write(2'd0, 32'h5A, 1'b0);
        bus_write(2'd1, 32'hFFFF_FFFF, 1'b1);
        bus_read(2'd2, v);
        check("reserved_rd", v, 32'd0);
        bus_read(2'd1, v);
        check("noeffect_status", v, IDLE_ST);
        repeat (4) @(negedge clk);

        // Single byte 0x55, bit-by-bit literal expectations
        bus_write(2'd0, 32'h1234_5655, 1'b1);
        @(negedge clk);
        check("pre_start_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("start_edge_tx", {31'd0, tx}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < NBITS; k++) begin
            check($sformatf("bit%0d_0x55", k), {31'd0, tx}, {31'd0, EXP55[k]});
            if (k == 4) begin
                bus_read(2'd1, v);
                check("busy_mid_frame", {31'd0, v[2]}, 32'd1);
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        bus_read(2'd1, v);
        check("after_frame_status", v, IDLE_ST);

        // Back-to-back 0x41..0x43
        write_burst(8'h41, 3);
        bus_read(2'd1, v);
        check("b2b_count", {28'd0, v[11:8]}, 32'd2);
        repeat (3 * FRAME + 8) @(negedge clk);
        bus_read(2'd1, v);
        check("b2b_done_status", v, IDLE_ST);

        // Overflow: ten writes into an eight-deep FIFO
        write_burst(8'h30, 10);
        bus_read(2'd1, v);
        check("ovf_set", {31'd0, v[3]}, 32'd1);
        check("ovf_full_count", {28'd0, v[11:8]}, 32'd8);
        check("ovf_full_flag", {31'd0, v[0]}, 32'd1);
        bus_read(2'd1, v);
        check("ovf_cleared", {31'd0, v[3]}, 32'd0);
        repeat (9 * FRAME + 8) @(negedge clk);
        bus_read(2'd1, v);
        check("ovf_done_status", v, IDLE_ST);

        // Reset during the data bits of 0xA5 with three bytes queued
        write_burst(8'hA5, 4);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midframe_reset_tx", {31'd0, tx}, 32'd1);
        reset = 1'b0;
        repeat (FRAME * 2) @(negedge clk);
        bus_read(2'd1, v);
        check("midframe_reset_status", v, IDLE_ST);

`ifdef MMIO_UART_TX_PARITY_EN
        // Parity bit values: 0x07 -> 1, 0x03 -> 0 (bit index 9 of the frame)
        bus_write(2'd0, 32'h07, 1'b1);
        repeat (2 + 1 + 9 * CPB) @(negedge clk);
        check("parity_0x07", {31'd0, tx}, 32'd1);
        repeat (2 * FRAME) @(negedge clk);
        bus_write(2'd0, 32'h03, 1'b1);
        repeat (2 + 1 + 9 * CPB) @(negedge clk);
        check("parity_0x03", {31'd0, tx}, 32'd0);
        repeat (2 * FRAME) @(negedge clk);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
